// File: rtl/weight_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : weight_mem_arbiter_if
//  Description : Bundle of the forward-read, weight-update and weight-RAM
//                signals around weight_mem_arbiter.
//                slave  : arbiter side (takes requests and mem_rdata, drives
//                         grants, read results and the RAM address/data/strobe)
//                master : requesters plus RAM side (the arbiter's environment)
//  Signals     : fwd_req/fwd_addr -> fwd_gnt/fwd_rvalid
//                upd_req/upd_we/upd_addr/upd_wdata/upd_lock -> upd_gnt/upd_rvalid
//                rd_data (shared read result), lock_err (sticky timeout flag)
//                mem_addr/mem_wdata/mem_we to the RAM, mem_rdata from the RAM
//  Revision    : 1.0  initial release
// ============================================================================
interface weight_mem_arbiter_if #(
    parameter int DATA_W = 256,
    parameter int ADDR_W = 4
);
    logic              fwd_req;
    logic [ADDR_W-1:0] fwd_addr;
    logic              fwd_gnt;
    logic              fwd_rvalid;

    logic              upd_req;
    logic              upd_we;
    logic [ADDR_W-1:0] upd_addr;
    logic [DATA_W-1:0] upd_wdata;
    logic              upd_lock;
    logic              upd_gnt;
    logic              upd_rvalid;

    logic [DATA_W-1:0] rd_data;
    logic              lock_err;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  fwd_req, fwd_addr,
        input  upd_req, upd_we, upd_addr, upd_wdata, upd_lock,
        input  mem_rdata,
        output fwd_gnt, fwd_rvalid, upd_gnt, upd_rvalid,
        output rd_data, lock_err,
        output mem_addr, mem_wdata, mem_we
    );

    modport master (
        output fwd_req, fwd_addr,
        output upd_req, upd_we, upd_addr, upd_wdata, upd_lock,
        output mem_rdata,
        input  fwd_gnt, fwd_rvalid, upd_gnt, upd_rvalid,
        input  rd_data, lock_err,
        input  mem_addr, mem_wdata, mem_we
    );
endinterface
`default_nettype wire

// File: rtl/weight_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : weight_mem_arbiter
//  Description : Two-requester arbiter for a single-port weight RAM.
//                The forward-pass engine issues reads; the weight-update
//                engine issues reads/writes and may lock the RAM across
//                consecutive accesses (read-modify-write). Grants are
//                combinational (zero-cycle); ties are resolved round-robin
//                and a lock is bounded to LOCK_MAX cycles, after which
//                lock_err is set (sticky until reset).
//  Ports       : clk, reset (synchronous, active-high)
//                bus : weight_mem_arbiter_if.slave (requests, grants,
//                      read results, RAM address/data/strobe)
//  Parameters  : DATA_W, ADDR_W, LOCK_MAX (1..15, lock counter is 4 bits)
//  Revision    : 1.0  initial release
// ============================================================================
module weight_mem_arbiter #(
    parameter int DATA_W   = 256,
    parameter int ADDR_W   = 4,
    parameter int LOCK_MAX = 15
) (
    input  wire logic             clk,
    input  wire logic             reset,
    weight_mem_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_LAST_FWD = 2'd1,
        S_LAST_UPD = 2'd2,
        S_LOCKED   = 2'd3
    } state_t;

    localparam logic [4:0] c_LOCK_MAX = 5'(LOCK_MAX);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [3:0]        r_lock_cnt;
    logic              r_lock_blk;     // upd_lock ignored after a timeout until it drops
    logic              r_lock_err;
    logic              r_fwd_rvalid;
    logic              r_upd_rvalid;
    logic [DATA_W-1:0] r_rd_data;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;

    logic              w_fwd_gnt;
    logic              w_upd_gnt;
    logic              w_lock_req;
    logic              w_timeout;
    logic              w_fwd_wins;

    // The counter holds the number of LOCKED cycles already completed, so
    // the timeout fires in the LOCK_MAX-th locked cycle.
    assign w_timeout  = (r_state == S_LOCKED) &&
                        (({1'b0, r_lock_cnt} + 5'd1) == c_LOCK_MAX);
    assign w_lock_req = bus.upd_lock & ~r_lock_blk;

    // Forward wins when it is alone, or on a tie unless it was served last.
    assign w_fwd_wins = bus.fwd_req && (!bus.upd_req || (r_state != S_LAST_FWD));

    // ------------------------------------------------------------------
    // Next-state and grant logic
    // ------------------------------------------------------------------
    always_comb begin
        w_fwd_gnt   = 1'b0;
        w_upd_gnt   = 1'b0;
        w_state_nxt = r_state;
        case (r_state)
            S_LOCKED: begin
                w_upd_gnt = bus.upd_req;
                if (w_timeout || !bus.upd_lock) begin
                    w_state_nxt = S_LAST_UPD;
                end
            end
            default: begin
                if (w_fwd_wins) begin
                    w_fwd_gnt   = 1'b1;
                    w_state_nxt = S_LAST_FWD;
                end else if (bus.upd_req) begin
                    w_upd_gnt   = 1'b1;
                    w_state_nxt = w_lock_req ? S_LOCKED : S_LAST_UPD;
                end
            end
        endcase
        // Reset masks grants immediately so nothing reaches the RAM in the
        // reset cycle itself.
        if (reset) begin
            w_fwd_gnt   = 1'b0;
            w_upd_gnt   = 1'b0;
            w_state_nxt = S_IDLE;
        end
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_lock_cnt   <= 4'd0;
            r_lock_blk   <= 1'b0;
            r_lock_err   <= 1'b0;
            r_fwd_rvalid <= 1'b0;
            r_upd_rvalid <= 1'b0;
            r_rd_data    <= '0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_lock_cnt <= (r_state == S_LOCKED) ? (r_lock_cnt + 4'd1) : 4'd0;

            if (w_timeout && bus.upd_lock) begin
                r_lock_blk <= 1'b1;
            end else if (!bus.upd_lock) begin
                r_lock_blk <= 1'b0;
            end

            if (w_timeout) begin
                r_lock_err <= 1'b1;
            end

            r_fwd_rvalid <= w_fwd_gnt;
            r_upd_rvalid <= w_upd_gnt & ~bus.upd_we;
            if (w_fwd_gnt || (w_upd_gnt && !bus.upd_we)) begin
                r_rd_data <= bus.mem_rdata;
            end

            if (w_fwd_gnt) begin
                r_mem_addr <= bus.fwd_addr;
            end else if (w_upd_gnt) begin
                r_mem_addr  <= bus.upd_addr;
                r_mem_wdata <= bus.upd_wdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs. Registered results are masked while reset is high so a
    // read granted just before reset never shows its rvalid.
    // ------------------------------------------------------------------
    assign bus.fwd_gnt    = w_fwd_gnt;
    assign bus.upd_gnt    = w_upd_gnt;
    assign bus.mem_we     = w_upd_gnt & bus.upd_we;
    assign bus.mem_addr   = reset     ? '0           :
                            w_fwd_gnt ? bus.fwd_addr :
                            w_upd_gnt ? bus.upd_addr : r_mem_addr;
    assign bus.mem_wdata  = reset     ? '0            :
                            w_upd_gnt ? bus.upd_wdata : r_mem_wdata;
    assign bus.fwd_rvalid = r_fwd_rvalid & ~reset;
    assign bus.upd_rvalid = r_upd_rvalid & ~reset;
    assign bus.rd_data    = reset ? '0 : r_rd_data;
    assign bus.lock_err   = r_lock_err & ~reset;

endmodule
`default_nettype wire

// File: tb/tb_weight_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_weight_mem_arbiter
//  Description : Self-checking bench for weight_mem_arbiter: a table of
//                directed cycles from reset, hand sequences for lock,
//                lock timeout and reset corner cases, then constrained
//                random traffic checked against a behavioural model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_weight_mem_arbiter;

    localparam int DATA_W   = 256;
    localparam int ADDR_W   = 4;
    localparam int LOCK_MAX = 15;

    logic clk;
    logic reset;

    weight_mem_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    weight_mem_arbiter #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .LOCK_MAX (LOCK_MAX)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    function automatic logic [DATA_W-1:0] rep(input logic [7:0] b);
        return {32{b}};
    endfunction

    task automatic chk_b(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0b expected %0b", nm, act, exp);
        end
    endtask

    task automatic chk_v(input string nm, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic fr, input logic [ADDR_W-1:0] fa,
                         input logic ur, input logic uwe,
                         input logic [ADDR_W-1:0] ua,
                         input logic [DATA_W-1:0] uwd, input logic ul,
                         input logic [DATA_W-1:0] rdat);
        bus.fwd_req   = fr;
        bus.fwd_addr  = fa;
        bus.upd_req   = ur;
        bus.upd_we    = uwe;
        bus.upd_addr  = ua;
        bus.upd_wdata = uwd;
        bus.upd_lock  = ul;
        bus.mem_rdata = rdat;
    endtask

    task automatic drive_idle(input logic [DATA_W-1:0] rdat);
        drive(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, rdat);
    endtask

    // Inputs change 1 time unit after the rising edge; checks run at +4.
    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        drive_idle('0);
        reset = 1'b1;
        next_cycle();
        next_cycle();
        reset = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Directed table (consecutive cycles starting right after reset)
    // ------------------------------------------------------------------
    typedef struct {
        logic              fr;
        logic [ADDR_W-1:0] fa;
        logic              ur;
        logic              uwe;
        logic [ADDR_W-1:0] ua;
        logic [7:0]        uwd;
        logic              ul;
        logic [7:0]        rdat;
        logic              e_fg;
        logic              e_ug;
        logic              e_we;
        logic [ADDR_W-1:0] e_addr;
        logic [7:0]        e_wd;
        logic              e_frv;
        logic              e_urv;
        logic [7:0]        e_rd;
    } vec_t;

    function automatic vec_t mk(
        input logic fr, input logic [3:0] fa, input logic ur, input logic uwe,
        input logic [3:0] ua, input logic [7:0] uwd, input logic ul,
        input logic [7:0] rdat,
        input logic e_fg, input logic e_ug, input logic e_we,
        input logic [3:0] e_addr, input logic [7:0] e_wd,
        input logic e_frv, input logic e_urv, input logic [7:0] e_rd);
        vec_t v;
        v.fr = fr; v.fa = fa; v.ur = ur; v.uwe = uwe; v.ua = ua; v.uwd = uwd;
        v.ul = ul; v.rdat = rdat; v.e_fg = e_fg; v.e_ug = e_ug; v.e_we = e_we;
        v.e_addr = e_addr; v.e_wd = e_wd; v.e_frv = e_frv; v.e_urv = e_urv;
        v.e_rd = e_rd;
        return v;
    endfunction

    vec_t vecs[10];

    // ------------------------------------------------------------------
    // Behavioural reference model
    // ------------------------------------------------------------------
    int              m_last;      // 0 nobody yet, 1 forward, 2 update
    bit              m_locked;
    int              m_lock_cycles;
    bit              m_ignore;
    bit              m_err;
    bit              m_frv, m_urv;
    logic [DATA_W-1:0] m_rd, m_wd;
    logic [ADDR_W-1:0] m_addr;
    bit              eg_f, eg_u;

    task automatic model_reset;
        m_last = 0; m_locked = 0; m_lock_cycles = 0; m_ignore = 0; m_err = 0;
        m_frv = 0; m_urv = 0; m_rd = '0; m_wd = '0; m_addr = '0;
    endtask

    task automatic model_grants;
        if (m_locked) begin
            eg_f = 1'b0;
            eg_u = bus.upd_req;
        end else if (bus.fwd_req && bus.upd_req) begin
            eg_f = (m_last != 1);
            eg_u = !eg_f;
        end else begin
            eg_f = bus.fwd_req;
            eg_u = bus.upd_req;
        end
    endtask

    task automatic model_step;
        m_frv = eg_f;
        m_urv = eg_u && !bus.upd_we;
        if (eg_f || (eg_u && !bus.upd_we)) m_rd = bus.mem_rdata;
        if (eg_f) m_addr = bus.fwd_addr;
        if (eg_u) begin
            m_addr = bus.upd_addr;
            m_wd   = bus.upd_wdata;
        end
        if (m_locked) begin
            m_lock_cycles++;
            if (m_lock_cycles == LOCK_MAX) begin
                m_locked = 0; m_err = 1; m_last = 2;
                if (bus.upd_lock) m_ignore = 1;
            end else if (!bus.upd_lock) begin
                m_locked = 0; m_last = 2;
            end
        end else begin
            if (eg_f) m_last = 1;
            if (eg_u) begin
                m_last = 2;
                if (bus.upd_lock && !m_ignore) begin
                    m_locked = 1;
                    m_lock_cycles = 0;
                end
            end
        end
        if (!bus.upd_lock) m_ignore = 0;
    endtask

    task automatic model_check;
        chk_b("rnd fwd_gnt",    bus.fwd_gnt,    eg_f);
        chk_b("rnd upd_gnt",    bus.upd_gnt,    eg_u);
        chk_b("rnd mem_we",     bus.mem_we,     eg_u && bus.upd_we);
        chk_v("rnd mem_addr",   DATA_W'(bus.mem_addr),
              DATA_W'(eg_f ? bus.fwd_addr : (eg_u ? bus.upd_addr : m_addr)));
        if (!eg_f)
            chk_v("rnd mem_wdata", bus.mem_wdata, eg_u ? bus.upd_wdata : m_wd);
        chk_b("rnd fwd_rvalid", bus.fwd_rvalid, m_frv);
        chk_b("rnd upd_rvalid", bus.upd_rvalid, m_urv);
        chk_v("rnd rd_data",    bus.rd_data,    m_rd);
        chk_b("rnd lock_err",   bus.lock_err,   m_err);
    endtask

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        vecs[0] = mk(1,0, 0,0,0,8'h00,0, 8'hA5,  1,0,0, 0,8'h00, 0,0, 8'h00);
        vecs[1] = mk(0,0, 0,0,0,8'h00,0, 8'h00,  0,0,0, 0,8'h00, 1,0, 8'hA5);
        vecs[2] = mk(1,3, 1,0,5,8'h00,0, 8'h11,  0,1,0, 5,8'h00, 0,0, 8'hA5);
        vecs[3] = mk(1,3, 1,0,6,8'h00,0, 8'h22,  1,0,0, 3,8'h00, 0,1, 8'h11);
        vecs[4] = mk(1,7, 1,0,6,8'h00,0, 8'h33,  0,1,0, 6,8'h00, 1,0, 8'h22);
        vecs[5] = mk(1,7, 0,0,0,8'h00,0, 8'h44,  1,0,0, 7,8'h00, 0,1, 8'h33);
        vecs[6] = mk(0,0, 1,1,2,8'h0F,0, 8'h55,  0,1,1, 2,8'h0F, 1,0, 8'h44);
        vecs[7] = mk(0,0, 0,0,0,8'h00,0, 8'h66,  0,0,0, 2,8'h0F, 0,0, 8'h44);
        vecs[8] = mk(0,0, 1,0,2,8'h0F,0, 8'h77,  0,1,0, 2,8'h0F, 0,0, 8'h44);
        vecs[9] = mk(0,0, 0,0,0,8'h00,0, 8'h00,  0,0,0, 2,8'h0F, 0,1, 8'h77);

        reset = 1'b1;
        drive_idle('0);
        next_cycle();
        do_reset();

        // Reset state
        #3;
        chk_b("reset fwd_gnt",  bus.fwd_gnt,  1'b0);
        chk_b("reset upd_gnt",  bus.upd_gnt,  1'b0);
        chk_b("reset mem_we",   bus.mem_we,   1'b0);
        chk_v("reset mem_addr", DATA_W'(bus.mem_addr), '0);
        chk_v("reset rd_data",  bus.rd_data,  '0);
        chk_b("reset lock_err", bus.lock_err, 1'b0);
        next_cycle();

        // Directed table
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].fr, vecs[i].fa, vecs[i].ur, vecs[i].uwe, vecs[i].ua,
                  rep(vecs[i].uwd), vecs[i].ul, rep(vecs[i].rdat));
            #3;
            chk_b($sformatf("vec%0d fwd_gnt", i),    bus.fwd_gnt,    vecs[i].e_fg);
            chk_b($sformatf("vec%0d upd_gnt", i),    bus.upd_gnt,    vecs[i].e_ug);
            chk_b($sformatf("vec%0d mem_we", i),     bus.mem_we,     vecs[i].e_we);
            chk_v($sformatf("vec%0d mem_addr", i),   DATA_W'(bus.mem_addr),
                  DATA_W'(vecs[i].e_addr));
            chk_v($sformatf("vec%0d mem_wdata", i),  bus.mem_wdata,  rep(vecs[i].e_wd));
            chk_b($sformatf("vec%0d fwd_rvalid", i), bus.fwd_rvalid, vecs[i].e_frv);
            chk_b($sformatf("vec%0d upd_rvalid", i), bus.upd_rvalid, vecs[i].e_urv);
            chk_v($sformatf("vec%0d rd_data", i),    bus.rd_data,    rep(vecs[i].e_rd));
            next_cycle();
        end

        // Locked read-modify-write blocks forward for both accesses;
        // the read returns the pre-write data.
        do_reset();
        drive(1, 0, 0, 0, 0, '0, 0, rep(8'h00));
        #3 chk_b("rmw pre fwd_gnt", bus.fwd_gnt, 1'b1);
        next_cycle();
        drive(1, 4, 1, 0, 1, '0, 1, rep(8'h99));
        #3;
        chk_b("rmw rd upd_gnt", bus.upd_gnt, 1'b1);
        chk_b("rmw rd fwd_gnt", bus.fwd_gnt, 1'b0);
        chk_v("rmw rd mem_addr", DATA_W'(bus.mem_addr), DATA_W'(1));
        next_cycle();
        drive(1, 4, 1, 1, 1, rep(8'h3C), 0, rep(8'h12));
        #3;
        chk_b("rmw wr upd_gnt",   bus.upd_gnt,    1'b1);
        chk_b("rmw wr fwd_gnt",   bus.fwd_gnt,    1'b0);
        chk_b("rmw wr mem_we",    bus.mem_we,     1'b1);
        chk_b("rmw wr upd_rvalid", bus.upd_rvalid, 1'b1);
        chk_v("rmw wr rd_data",   bus.rd_data,    rep(8'h99));
        next_cycle();
        drive(1, 4, 0, 0, 0, '0, 0, rep(8'h00));
        #3;
        chk_b("rmw post fwd_gnt",    bus.fwd_gnt,    1'b1);
        chk_v("rmw post mem_addr",   DATA_W'(bus.mem_addr), DATA_W'(4));
        chk_b("rmw post upd_rvalid", bus.upd_rvalid, 1'b0);
        chk_b("rmw post mem_we",     bus.mem_we,     1'b0);
        next_cycle();

        // Lock held for 20 cycles with forward waiting: timeout after
        // LOCK_MAX locked cycles, lock_err sticky, held lock then ignored.
        do_reset();
        drive(1, 1, 0, 0, 0, '0, 0, '0);
        next_cycle();
        for (int k = 0; k < 20; k++) begin
            drive(1, 2, 1, 0, 3, '0, 1, '0);
            #3;
            if (k == 0) begin
                chk_b("lock entry upd_gnt", bus.upd_gnt, 1'b1);
            end else if (k <= LOCK_MAX) begin
                chk_b($sformatf("lock k%0d fwd_gnt", k), bus.fwd_gnt, 1'b0);
                chk_b($sformatf("lock k%0d upd_gnt", k), bus.upd_gnt, 1'b1);
                chk_b($sformatf("lock k%0d lock_err", k), bus.lock_err, 1'b0);
            end else begin
                chk_b($sformatf("lock k%0d fwd_gnt", k), bus.fwd_gnt, (k % 2) == 0);
                chk_b($sformatf("lock k%0d upd_gnt", k), bus.upd_gnt, (k % 2) == 1);
                chk_b($sformatf("lock k%0d lock_err", k), bus.lock_err, 1'b1);
            end
            next_cycle();
        end
        drive_idle('0);
        next_cycle();
        #3 chk_b("lock_err sticky", bus.lock_err, 1'b1);
        next_cycle();

        // Reset the cycle after a granted read
        drive(1, 5, 0, 0, 0, '0, 0, rep(8'hA5));
        #3 chk_b("rstrd fwd_gnt", bus.fwd_gnt, 1'b1);
        next_cycle();
        reset = 1'b1;
        drive_idle(rep(8'h5A));
        #3;
        chk_b("rstrd in fwd_rvalid", bus.fwd_rvalid, 1'b0);
        chk_b("rstrd in lock_err",   bus.lock_err,   1'b0);
        next_cycle();
        reset = 1'b0;
        #3;
        chk_b("rstrd out fwd_rvalid", bus.fwd_rvalid, 1'b0);
        chk_b("rstrd out upd_rvalid", bus.upd_rvalid, 1'b0);
        chk_v("rstrd out rd_data",    bus.rd_data,    '0);
        chk_v("rstrd out mem_addr",   DATA_W'(bus.mem_addr), '0);
        chk_v("rstrd out mem_wdata",  bus.mem_wdata,  '0);
        chk_b("rstrd out lock_err",   bus.lock_err,   1'b0);
        next_cycle();
        // Fresh IDLE: forward wins the first tie even with a lock request.
        drive(1, 6, 1, 0, 7, '0, 1, '0);
        #3 chk_b("rst idle tie fwd_gnt", bus.fwd_gnt, 1'b1);
        next_cycle();

        // Randomized traffic against the model
        do_reset();
        model_reset();
        begin
            bit                fp, up;
            logic [ADDR_W-1:0] fa, ua;
            logic              uwe, ul;
            logic [DATA_W-1:0] uwd, rdat;
            int                lrun;
            fp = 0; up = 0; fa = '0; ua = '0; uwe = 0; ul = 0; uwd = '0; lrun = 0;
            for (int n = 0; n < 600; n++) begin
                if (!fp) begin
                    fp = ($urandom_range(0, 1) == 1);
                    fa = ADDR_W'($urandom);
                end
                if (!up) begin
                    up  = ($urandom_range(0, 2) != 0);
                    uwe = ($urandom_range(0, 1) == 1);
                    ua  = ADDR_W'($urandom);
                    uwd = {$urandom, $urandom, $urandom, $urandom,
                           $urandom, $urandom, $urandom, $urandom};
                end
                if (lrun > 0) begin
                    ul = 1'b1;
                    lrun--;
                end else if ($urandom_range(0, 24) == 0) begin
                    lrun = $urandom_range(2, 24);
                    ul   = 1'b1;
                end else begin
                    ul = ($urandom_range(0, 3) == 0);
                end
                rdat = {$urandom, $urandom, $urandom, $urandom,
                        $urandom, $urandom, $urandom, $urandom};
                drive(fp, fa, up, uwe, ua, uwd, ul, rdat);
                #3;
                model_grants();
                model_check();
                model_step();
                if (eg_f) fp = 0;
                if (eg_u) up = 0;
                next_cycle();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
